// File: rtl/mux_arbiter_pkg.sv
// Shared definitions for the two-requester beat arbiter.
//   state_t          : arbiter FSM encoding (IDLE = 0, SERVE_A = 1, SERVE_B = 2)
//   DEFAULT_WIDTH    : default payload width
//   DEFAULT_MAX_HOLD : default beat limit per requester while the other waits
package mux_arbiter_pkg;

  localparam int unsigned DEFAULT_WIDTH    = 8;
  localparam int unsigned DEFAULT_MAX_HOLD = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_A = 2'd1,
    SERVE_B = 2'd2
  } state_t;

endpackage

// File: rtl/mux_arbiter_mux2.sv
// Single-bit 2:1 multiplexer, the shared datapath cell.
//   a : selected when s = 0
//   b : selected when s = 1
//   s : select
//   y : selected bit
module mux_arbiter_mux2 (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic y
);

  assign y = s ? b : a;

endmodule

// File: rtl/mux_arbiter.sv
// Two-requester arbiter feeding one registered output beat.
// Requesters are served in bursts of up to MAX_HOLD beats when both are
// active; a lone requester keeps being served indefinitely.
//   clk, rst         : clock, asynchronous active-high reset
//   req_a, data_a    : requester A beat available / payload
//   req_b, data_b    : requester B beat available / payload
//   grant_a, grant_b : strobe, the requester's beat is accepted this cycle
//   sel              : datapath select (0 = A, 1 = B)
//   out_valid        : out_data holds a beat
//   out_data         : registered output beat
//   out_ready        : downstream accepts out_data when out_valid is high
module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned MAX_HOLD = DEFAULT_MAX_HOLD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             grant_a,
  output logic             grant_b,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  state_t           state, state_next;
  logic             last_b;
  logic [HW-1:0]    hold;
  logic             sel_q;
  logic             space;
  logic             accept;
  logic             at_limit;
  logic [WIDTH-1:0] mux_data;

  assign space  = !out_valid || out_ready;
  assign accept = grant_a || grant_b;

  // The limit is judged on the count including this cycle's accept, so the
  // hand-over happens right after the MAX_HOLD-th beat with no extra beat.
  assign at_limit = (hold == HOLD_MAX) || (accept && hold == HOLD_LAST);

  always_comb begin
    sel     = sel_q;
    grant_a = 1'b0;
    grant_b = 1'b0;
    case (state)
      SERVE_A: begin
        sel     = 1'b0;
        grant_a = req_a && space;
      end
      SERVE_B: begin
        sel     = 1'b1;
        grant_b = req_b && space;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_a && req_b) state_next = last_b ? SERVE_A : SERVE_B;
        else if (req_a)     state_next = SERVE_A;
        else if (req_b)     state_next = SERVE_B;
      end
      SERVE_A: begin
        if (!req_a)                state_next = req_b ? SERVE_B : IDLE;
        else if (at_limit && req_b) state_next = SERVE_B;
      end
      SERVE_B: begin
        if (!req_b)                state_next = req_a ? SERVE_A : IDLE;
        else if (at_limit && req_a) state_next = SERVE_A;
      end
      default: state_next = IDLE;
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_mux
    mux_arbiter_mux2 u_mux (
      .a (data_a[i]),
      .b (data_b[i]),
      .s (sel),
      .y (mux_data[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      last_b <= 1'b1;
      hold   <= '0;
      sel_q  <= 1'b0;
    end else begin
      state <= state_next;
      sel_q <= sel;
      if (state_next == SERVE_A && state != SERVE_A) last_b <= 1'b0;
      else if (state_next == SERVE_B && state != SERVE_B) last_b <= 1'b1;
      if (state_next != state)              hold <= '0;
      else if (accept && hold != HOLD_MAX)  hold <= hold + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= mux_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter: directed cycle vectors with
// hand-computed grants/sel/out_valid, a queue of expected beats, and a
// monitor that pops the queue whenever a beat leaves the arbiter.
module tb_mux_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_a = 1'b0, req_b = 1'b0, out_ready = 1'b0;
  logic [7:0] data_a = '0, data_b = '0;
  logic       grant_a, grant_b, sel, out_valid;
  logic [7:0] out_data;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  int         na = 0, nb = 0;
  logic [7:0] base_a = '0, base_b = '0;
  logic       inc_a = 1'b1, inc_b = 1'b1;

  mux_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_a     (req_a),
    .data_a    (data_a),
    .req_b     (req_b),
    .data_b    (data_b),
    .grant_a   (grant_a),
    .grant_b   (grant_b),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: every beat leaving the arbiter must be the oldest expected one.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL beat_unexpected: got %0h expected none", out_data);
        end else begin
          chk("beat", int'(out_data), int'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // One cycle: drive at posedge+1, check at negedge (-1 = don't care).
  task automatic cyc(input string tag, input logic ra, input logic rb, input logic rdy,
                     input int ega, input int egb, input int esel, input int eov,
                     input int edata);
    req_a     = ra;
    req_b     = rb;
    out_ready = rdy;
    data_a    = inc_a ? 8'(int'(base_a) + na) : base_a;
    data_b    = inc_b ? 8'(int'(base_b) + nb) : base_b;
    @(negedge clk);
    if (ega  >= 0) chk({tag, "_grant_a"},   int'(grant_a),   ega);
    if (egb  >= 0) chk({tag, "_grant_b"},   int'(grant_b),   egb);
    if (esel >= 0) chk({tag, "_sel"},       int'(sel),       esel);
    if (eov  >= 0) chk({tag, "_out_valid"}, int'(out_valid), eov);
    if (edata >= 0) chk({tag, "_out_data"}, int'(out_data),  edata);
    if (grant_a) na++;
    if (grant_b) nb++;
    @(posedge clk);
    #1;
  endtask

  // Assert reset mid-cycle, check outputs clear before any edge, release.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, "_rst_grant_a"},   int'(grant_a),   0);
    chk({tag, "_rst_grant_b"},   int'(grant_b),   0);
    chk({tag, "_rst_sel"},       int'(sel),       0);
    chk({tag, "_rst_out_valid"}, int'(out_valid), 0);
    chk({tag, "_rst_out_data"},  int'(out_data),  0);
    @(posedge clk);
    #1;
    exp_q.delete();
    na = 0;
    nb = 0;
    rst = 1'b0;
  endtask

  initial begin
    #2;
    do_reset("init");

    // Lone requester A, constant payload 0x11.
    inc_a = 1'b0; base_a = 8'h11;
    repeat (4) exp_q.push_back(8'h11);
    cyc("a_only0", 1, 0, 1, 0, 0, 0, 0, -1);
    cyc("a_only1", 1, 0, 1, 1, 0, 0, 0, -1);
    for (int i = 0; i < 3; i++) cyc("a_only2", 1, 0, 1, 1, 0, 0, 1, 8'h11);
    // Fourth beat still in the output register: reset must discard it.
    chk("pending_before_reset", exp_q.size(), 1);
    do_reset("mid_beat");

    // Backpressure: one beat held for 5 cycles, next grant on release.
    inc_a = 1'b1; base_a = 8'h20;
    exp_q.push_back(8'h20);
    exp_q.push_back(8'h21);
    cyc("bp0", 1, 0, 1, 0, 0, 0, 0, -1);
    cyc("bp1", 1, 0, 0, 1, 0, 0, 0, -1);
    for (int i = 0; i < 4; i++) cyc("bp_hold", 1, 0, 0, 0, 0, 0, 1, 8'h20);
    cyc("bp_release", 1, 0, 1, 1, 0, 0, 1, 8'h20);
    cyc("bp_drop",    0, 0, 1, 0, 0, 0, 1, 8'h21);
    cyc("bp_idle",    0, 0, 1, 0, 0, 0, 0, 8'h21);
    chk("bp_drained", exp_q.size(), 0);
    do_reset("t3");

    // Both requesting: A wins first tie, bursts of 4 alternate with no gap.
    base_a = 8'hA0; base_b = 8'hB0; inc_b = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(8'hA0 + 8'(i));
    for (int i = 0; i < 4; i++) exp_q.push_back(8'hB0 + 8'(i));
    for (int i = 4; i < 8; i++) exp_q.push_back(8'hA0 + 8'(i));
    cyc("rr0", 1, 1, 1, 0, 0, 0, 0, -1);
    cyc("rr_a1", 1, 1, 1, 1, 0, 0, 0, -1);
    for (int i = 0; i < 3; i++) cyc("rr_a", 1, 1, 1, 1, 0, 0, 1, -1);
    for (int i = 0; i < 4; i++) cyc("rr_b", 1, 1, 1, 0, 1, 1, 1, -1);
    for (int i = 0; i < 4; i++) cyc("rr_a2", 1, 1, 1, 1, 0, 0, 1, -1);
    cyc("rr_stop", 0, 0, 1, 0, 0, 1, 1, 8'hA7);
    cyc("rr_idle", 0, 0, 1, 0, 0, 1, 0, -1);
    chk("rr_drained", exp_q.size(), 0);
    do_reset("t4");

    // A saturates its hold count alone, then drops as B arrives.
    base_a = 8'hC0; base_b = 8'hD0;
    for (int i = 0; i < 5; i++) exp_q.push_back(8'hC0 + 8'(i));
    exp_q.push_back(8'hD0);
    cyc("hd0", 1, 0, 1, 0, 0, 0, 0, -1);
    cyc("hd1", 1, 0, 1, 1, 0, 0, 0, -1);
    for (int i = 0; i < 4; i++) cyc("hd_a", 1, 0, 1, 1, 0, 0, 1, -1);
    cyc("hd_swap", 0, 1, 1, 0, 0, 0, 1, 8'hC4);
    cyc("hd_b",    0, 1, 1, 0, 1, 1, 0, -1);
    cyc("hd_stop", 0, 0, 1, 0, 0, 1, 1, 8'hD0);
    cyc("hd_idle", 0, 0, 1, 0, 0, 1, 0, -1);
    chk("hd_drained", exp_q.size(), 0);
    do_reset("t5");

    // Random traffic: beats must come out in grant order, none lost or doubled.
    base_a = 8'h00; base_b = 8'h80;
    for (int i = 0; i < 3000; i++) begin
      req_a     = 1'($urandom_range(0, 3) != 0);
      req_b     = 1'($urandom_range(0, 2) != 0);
      out_ready = 1'($urandom_range(0, 3) != 0);
      data_a    = 8'(int'(base_a) + na);
      data_b    = 8'(int'(base_b) + nb);
      @(negedge clk);
      chk("rand_excl", int'(grant_a && grant_b), 0);
      if (grant_a) begin exp_q.push_back(data_a); na++; end
      if (grant_b) begin exp_q.push_back(data_b); nb++; end
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 4; i++) cyc("rand_drain", 0, 0, 1, 0, 0, -1, -1, -1);
    chk("rand_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
